// File: rtl/spi_pot_master_if.sv
// Control-side handshake plus the SPI pins of the potentiometer write master.
// The slave modport is the master block itself; the master modport is its controller.
interface spi_pot_master_if;
  logic [7:0] wiper_val;
  logic       wiper_valid;
  logic       wiper_ready;
  logic       busy;
  logic       done;
  logic       overwrite;
  logic       scl;
  logic       sda;
  logic       csn;

  modport master (
    output wiper_val, wiper_valid,
    input  wiper_ready, busy, done, overwrite, scl, sda, csn
  );

  modport slave (
    input  wiper_val, wiper_valid,
    output wiper_ready, busy, done, overwrite, scl, sda, csn
  );
endinterface

// File: rtl/spi_pot_master.sv
// SPI mode-0 write master: sends {CMD, wiper} frames MSB first, with a
// one-entry latest-wins pending register so updates never stall the controller.
module spi_pot_master #(
  parameter int         CLK_DIV  = 4,
  parameter int         CS_SETUP = 2,
  parameter int         CS_HOLD  = 2,
  parameter int         CS_IDLE  = 4,
  parameter logic [7:0] CMD      = 8'h11
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_pot_master_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             half_reg, half_next;
  logic [3:0]       bit_reg, bit_next;
  logic [15:0]      shift_reg, shift_next;
  logic             pend_full_reg, pend_full_next;
  logic [7:0]       pend_val_reg, pend_val_next;

  logic ready_reg;
  logic csn_reg, csn_next;
  logic scl_reg, scl_next;
  logic sda_reg, sda_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic overwrite_reg, overwrite_next;

  logic accept;
  assign accept = bus.wiper_valid && ready_reg;

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      half_reg      <= 1'b0;
      bit_reg       <= 4'd0;
      shift_reg     <= 16'd0;
      pend_full_reg <= 1'b0;
      pend_val_reg  <= 8'd0;
      ready_reg     <= 1'b0;
      csn_reg       <= 1'b1;
      scl_reg       <= 1'b0;
      sda_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      overwrite_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      half_reg      <= half_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      pend_full_reg <= pend_full_next;
      pend_val_reg  <= pend_val_next;
      ready_reg     <= 1'b1;
      csn_reg       <= csn_next;
      scl_reg       <= scl_next;
      sda_reg       <= sda_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      overwrite_reg <= overwrite_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    half_next      = half_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    pend_full_next = pend_full_reg;
    pend_val_next  = pend_val_reg;
    overwrite_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pend_full_reg || accept) begin
          state_next = SETUP;
          cnt_next   = '0;
          shift_next = {CMD, pend_full_reg ? pend_val_reg : bus.wiper_val};
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = SHIFT;
          cnt_next   = '0;
          half_next  = 1'b0;
          bit_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (!half_reg) begin
            half_next = 1'b1;
          end else begin
            half_next = 1'b0;
            // Last bit is not shifted out so sda keeps it through HOLD.
            if (bit_reg == 4'd15) begin
              state_next = HOLD;
            end else begin
              bit_next   = bit_reg + 4'd1;
              shift_next = {shift_reg[14:0], 1'b0};
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A launch from pending frees the slot in the same cycle a new value may fill it.
    if (state_reg == IDLE && pend_full_reg) begin
      pend_full_next = accept;
      if (accept) pend_val_next = bus.wiper_val;
    end else if (accept && state_reg != IDLE) begin
      pend_full_next = 1'b1;
      pend_val_next  = bus.wiper_val;
      overwrite_next = pend_full_reg;
    end
  end

  // Outputs are registered from the next-state view so they line up with state_reg.
  always_comb begin
    csn_next  = !(state_next == SETUP || state_next == SHIFT || state_next == HOLD);
    scl_next  = (state_next == SHIFT) && half_next;
    sda_next  = csn_next ? 1'b0 : shift_next[15];
    done_next = (state_reg == HOLD) && (state_next == GAP);
    busy_next = (state_next != IDLE) || pend_full_next;
  end

  assign bus.wiper_ready = ready_reg;
  assign bus.csn         = csn_reg;
  assign bus.scl         = scl_reg;
  assign bus.sda         = sda_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.overwrite   = overwrite_reg;

endmodule
